// File: rtl/uart_tx_feeder_pkg.sv
// Shared widths and sequencer state encodings for the UART transmit feeder.
package uart_tx_feeder_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 2'd1;
    localparam logic [STATE_W-1:0] ST_WAITHI = 2'd2;
    localparam logic [STATE_W-1:0] ST_WAITLO = 2'd3;

endpackage

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Synchronous byte FIFO with wrapping binary pointers and a level counter.
// Head data is presented combinationally; flush beats push and pop.
module byte_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTHLOG2 = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 flush,
    input  logic [BYTE_W-1:0]    din,
    output logic [BYTE_W-1:0]    dout,
    output logic [DEPTHLOG2:0]   level
);

    localparam int unsigned DEPTH = 2 ** DEPTHLOG2;
    localparam int unsigned LVL_W = DEPTHLOG2 + 1;

    logic [BYTE_W-1:0]    mem [DEPTH];
    logic [DEPTHLOG2-1:0] wr_ptr;
    logic [DEPTHLOG2-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
    assign push_ok = push && (level != LVL_W'(DEPTH));
    assign pop_ok  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + DEPTHLOG2'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + DEPTHLOG2'(1);
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue plus load sequencer in front of the UART transmitter: pops one
// byte at a time, pulses load, then waits for txbusy to rise and fall.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int unsigned DEPTHLOG2 = 4,
    parameter int unsigned BUSYWAIT  = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [BYTE_W-1:0]    wr_data,
    input  logic                 flush,
    input  logic                 txbusy,
    output logic                 load,
    output logic [BYTE_W-1:0]    d,
    output logic                 full,
    output logic                 empty,
    output logic [DEPTHLOG2:0]   level,
    output logic                 overflow
);

    localparam int unsigned DEPTH = 2 ** DEPTHLOG2;
    localparam int unsigned LVL_W = DEPTHLOG2 + 1;
    localparam int unsigned CNT_W = $clog2(BUSYWAIT + 1);

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] state_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [BYTE_W-1:0]  d_next;
    logic [BYTE_W-1:0]  head;
    logic               load_next;
    logic               pop;

    assign full  = (level == LVL_W'(DEPTH));
    assign empty = (level == '0);

    byte_fifo #(
        .DEPTHLOG2 (DEPTHLOG2)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (wr_en),
        .pop    (pop),
        .flush  (flush),
        .din    (wr_data),
        .dout   (head),
        .level  (level)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            d        <= '0;
            load     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            d        <= d_next;
            load     <= load_next;
            overflow <= wr_en && full;
        end
    end

    // A same-cycle flush wins over the pop, so a flushed byte is never launched.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        d_next     = d;
        load_next  = 1'b0;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && !txbusy && !flush) begin
                    pop        = 1'b1;
                    d_next     = head;
                    load_next  = 1'b1;
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_next   = '0;
                state_next = ST_WAITHI;
            end
            ST_WAITHI: begin
                if (txbusy) begin
                    state_next = ST_WAITLO;
                end else if (cnt == CNT_W'(BUSYWAIT - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_WAITLO: begin
                if (!txbusy) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomised and directed bench for uart_tx_feeder against a queue-based model
// with a behavioural UART transmitter/receiver stub driving txbusy.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTHLOG2 = 4;
    localparam int unsigned BUSYWAIT  = 8;
    localparam int unsigned DEPTH     = 2 ** DEPTHLOG2;
    localparam int          FRAME     = 80;

    logic             clk = 1'b0;
    logic             resetn = 1'b1;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_data = 8'h00;
    logic             flush = 1'b0;
    logic             txbusy = 1'b0;
    logic             load;
    logic [7:0]       d;
    logic             full;
    logic             empty;
    logic [DEPTHLOG2:0] level;
    logic             overflow;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural model state
    logic [7:0] mq[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_log[$];
    int         load_times[$];
    bit         engaged = 1'b0;
    int         since = 0;
    bit         rose = 1'b0;
    logic       e_load = 1'b0;
    logic [7:0] e_d = 8'h00;
    logic       e_ovf = 1'b0;

    // UART stub state
    bit         stub_dead = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] frame_byte = 8'h00;

    logic [7:0] prev_d = 8'h00;
    logic       prev_busy = 1'b0;

    uart_tx_feeder #(
        .DEPTHLOG2 (DEPTHLOG2),
        .BUSYWAIT  (BUSYWAIT)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .txbusy   (txbusy),
        .load     (load),
        .d        (d),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Transmitter/receiver stub: busy for FRAME cycles after a sampled load.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_cnt = 0;
            txbusy <= 1'b0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                txbusy <= 1'b0;
                rx_log.push_back(frame_byte);
                if (tx_exp.size() == 0) chk("rx_extra_byte", 32'(tx_exp.size()), 32'd1);
                else                    chk("rx_byte", frame_byte, tx_exp.pop_front());
            end
        end else if (load && !stub_dead) begin
            busy_cnt   = FRAME;
            txbusy    <= 1'b1;
            frame_byte = d;
        end
    end

    // Reference model: queue of stored bytes plus timing of the one in flight.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            tx_exp.delete();
            engaged = 1'b0;
            since   = 0;
            rose    = 1'b0;
            e_load  = 1'b0;
            e_d     = 8'h00;
            e_ovf   = 1'b0;
        end else begin
            int  lvl0;
            bit  do_pop;
            lvl0   = mq.size();
            do_pop = !engaged && lvl0 != 0 && !txbusy && !flush;
            if (engaged) begin
                since++;
                if (since >= 2) begin
                    if (!rose) begin
                        if (txbusy) rose = 1'b1;
                        else if (since - 1 == BUSYWAIT) engaged = 1'b0;
                    end else if (!txbusy) begin
                        engaged = 1'b0;
                    end
                end
            end
            e_load = do_pop;
            if (do_pop) begin
                e_d     = mq.pop_front();
                engaged = 1'b1;
                since   = 0;
                rose    = 1'b0;
                if (!stub_dead) tx_exp.push_back(e_d);
            end
            e_ovf = wr_en && (lvl0 == DEPTH);
            if (flush) mq.delete();
            else if (wr_en && lvl0 < DEPTH) mq.push_back(wr_data);
        end
    end

    // Per-cycle comparison against the model, plus the txbusy invariants.
    always @(negedge clk) begin
        chk("load", load, e_load);
        chk("d", d, e_d);
        chk("level", level, mq.size());
        chk("full", full, mq.size() == DEPTH);
        chk("empty", empty, mq.size() == 0);
        chk("overflow", overflow, e_ovf);
        if (txbusy && prev_busy) chk("d_stable_while_busy", d, prev_d);
        if (load) chk("load_while_busy", txbusy, 1'b0);
        if (load) load_times.push_back(cyc);
        prev_d    = d;
        prev_busy = txbusy;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk("rx_count", rx_log.size(), n);
    endtask

    task automatic wait_busy(input int budget);
        int k = 0;
        while (!txbusy && k < budget) begin
            tick();
            k++;
        end
        chk("busy_seen", txbusy, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while ((mq.size() != 0 || engaged || txbusy) && k < budget) begin
            tick();
            k++;
        end
        chk("drained", {engaged, txbusy, mq.size() != 0}, 3'b000);
        repeat (2) tick();
    endtask

    initial begin
        int n0;
        #1 resetn = 1'b0;
        tick();
        chk("rst_load", load, 1'b0);
        chk("rst_d", d, 8'h00);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        tick();
        resetn = 1'b1;
        tick();

        // Two bytes one cycle apart: load for c1 two clocks after its push.
        push(8'hc1);
        chk("t1_level_after_push", level, 1);
        push(8'h4e);
        chk("t1_load", load, 1'b1);
        chk("t1_d", d, 8'hc1);
        chk("t1_level", level, 1);
        wait_rx(2, 400);
        if (rx_log.size() >= 2) begin
            chk("t1_rx0", rx_log[0], 8'hc1);
            chk("t1_rx1", rx_log[1], 8'h4e);
        end
        wait_drain(200);

        // Fill to full behind an in-flight byte, then overflow with ff.
        n0 = rx_log.size();
        for (int i = 0; i <= 16; i++) push(8'(i));
        push(8'hff);
        chk("t2_full", full, 1'b1);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_level", level, DEPTH);
        tick();
        chk("t2_overflow_pulse_end", overflow, 1'b0);
        wait_rx(n0 + 17, 17 * (FRAME + 10));
        if (rx_log.size() >= n0 + 17) begin
            chk("t2_first", rx_log[n0], 8'h00);
            chk("t2_last", rx_log[n0 + 16], 8'h10);
        end
        wait_drain(300);

        // Flush with a same-cycle push while three bytes wait behind one in flight.
        n0 = rx_log.size();
        push(8'ha0); push(8'ha1); push(8'ha2); push(8'ha3);
        wait_busy(20);
        chk("t3_level_before", level, 3);
        wr_en = 1'b1; wr_data = 8'hee; flush = 1'b1;
        tick();
        wr_en = 1'b0; flush = 1'b0;
        chk("t3_level_after", level, 0);
        chk("t3_empty_after", empty, 1'b1);
        load_times.delete();
        wait_drain(FRAME + 40);
        chk("t3_rx_count", rx_log.size(), n0 + 1);
        if (rx_log.size() == n0 + 1) chk("t3_rx_byte", rx_log[n0], 8'ha0);
        chk("t3_no_more_loads", load_times.size(), 0);

        // Dead UART: give up after BUSYWAIT cycles, next load one idle cycle later.
        stub_dead = 1'b1;
        load_times.delete();
        push(8'h5a);
        push(8'h77);
        repeat (30) tick();
        chk("t4_load_count", load_times.size(), 2);
        if (load_times.size() >= 2) chk("t4_load_gap", load_times[1] - load_times[0], BUSYWAIT + 2);
        chk("t4_d_last", d, 8'h77);
        stub_dead = 1'b0;
        wait_drain(50);

        // Reset while waiting for txbusy to fall.
        push(8'h81);
        wait_busy(20);
        repeat (5) tick();
        n0 = rx_log.size();
        resetn = 1'b0;
        #1;
        chk("t5_load", load, 1'b0);
        chk("t5_d", d, 8'h00);
        chk("t5_empty", empty, 1'b1);
        chk("t5_level", level, 0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        push(8'h33);
        wait_rx(n0 + 1, FRAME + 40);
        if (rx_log.size() >= n0 + 1) chk("t5_rx", rx_log[n0], 8'h33);
        wait_drain(50);

        // Random traffic with varying push rates and occasional flushes.
        for (int i = 0; i < 2500; i++) begin
            int rate;
            rate    = (i < 800) ? 60 : (i < 1600) ? 3 : 30;
            wr_en   = ($urandom_range(0, 99) < rate);
            wr_data = 8'($urandom);
            flush   = ($urandom_range(0, 299) == 0);
            tick();
        end
        wr_en = 1'b0;
        flush = 1'b0;
        wait_drain((DEPTH + 2) * (FRAME + 10));
        chk("final_tx_exp_left", tx_exp.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
